// File: rtl/divisor_seq_pkg.sv
// Shared encodings and defaults for the sequential ALU blocks (divider and future siblings).
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package divisor_seq_pkg;

  // Default operand width for the sequential ALU datapaths
  localparam int DIV_WIDTH = 3;

  // Common three-phase sequence: wait for start, iterate, hold result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divisor_seq_div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module divisor_seq_div_step
  import divisor_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_prem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dr,
  output logic [WIDTH-1:0] o_prem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  // The partial remainder stays below the divisor, so WIDTH+1 bits hold the trial result and its sign.
  assign w_shift = {i_prem, i_bit};
  assign w_trial = w_shift - {1'b0, i_dr};

  // Non-negative trial means the divisor fits: keep the difference and emit a 1.
  assign o_qbit = ~w_trial[WIDTH];
  assign o_prem = o_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/divisor_seq.sv
// Sequential restoring divider DV/DR started by a rising edge on init; optional DIVISOR_ZERO_TRAP_EN short-cuts DR=0.
// Latency: done rises WIDTH edges after the capture edge (1 edge for a trapped DR=0).
// Backpressure: result and done are held while init stays high; init low returns to IDLE (aborts an ongoing CALC).
module divisor_seq
  import divisor_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [WIDTH-1:0] DV,
  input  logic [WIDTH-1:0] DR,
  output logic [WIDTH-1:0] sal,
  output logic [WIDTH-1:0] rem,
  output logic             done,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_init_q;
  logic [WIDTH-1:0] r_dividend;  // shifts out dividend bits, shifts in quotient bits
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_prem;
  logic [WIDTH-1:0] r_sal;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  logic             w_start;
  logic             w_last;
  logic             w_trap;
  logic [WIDTH-1:0] w_prem_nxt;
  logic             w_qbit;

  assign w_start = init & ~r_init_q;
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

`ifdef DIVISOR_ZERO_TRAP_EN
  logic r_dbz;
  assign w_trap = (r_divisor == '0);
  assign dbz    = r_dbz;
`else
  assign w_trap = 1'b0;
  assign dbz    = 1'b0;
`endif

  divisor_seq_div_step #(.WIDTH(WIDTH)) u_step (
    .i_prem (r_prem),
    .i_bit  (r_dividend[WIDTH-1]),
    .i_dr   (r_divisor),
    .o_prem (w_prem_nxt),
    .o_qbit (w_qbit)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: init low always wins so an abort never flags a result
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = CALC;
      CALC: begin
        if (!init)                 w_state_nxt = IDLE;
        else if (w_trap || w_last) w_state_nxt = DONE;
      end
      DONE:    if (!init) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, one restoring step per CALC cycle, result load and hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_init_q   <= 1'b0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_prem     <= '0;
      r_cnt      <= '0;
      r_sal      <= '0;
      r_rem      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_init_q <= init;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_dividend <= DV;
            r_divisor  <= DR;
            r_prem     <= '0;
            r_cnt      <= '0;
          end
        end
        CALC: begin
          if (init) begin
            if (w_trap) begin
              r_sal  <= '1;
              r_rem  <= r_dividend;
              r_done <= 1'b1;
            end else begin
              r_prem     <= w_prem_nxt;
              r_dividend <= {r_dividend[WIDTH-2:0], w_qbit};
              r_cnt      <= r_cnt + CW'(1);
              if (w_last) begin
                r_sal  <= {r_dividend[WIDTH-2:0], w_qbit};
                r_rem  <= w_prem_nxt;
                r_done <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          if (!init) r_done <= 1'b0;
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

`ifdef DIVISOR_ZERO_TRAP_EN
  // Divide-by-zero flag lives exactly as long as the trapped result's DONE period
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          r_dbz <= 1'b0;
    else if (r_state == CALC && init && w_trap)       r_dbz <= 1'b1;
    else if (r_state == DONE && !init)                r_dbz <= 1'b0;
  end
`endif

  assign sal  = r_sal;
  assign rem  = r_rem;
  assign done = r_done;

endmodule

// File: tb/tb_divisor_seq.sv
module tb_divisor_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       init;
  logic [2:0] DV;
  logic [2:0] DR;
  logic [2:0] sal;
  logic [2:0] rem;
  logic       done;
  logic       dbz;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [2:0] dv;
    logic [2:0] dr;
    logic [2:0] q;
    logic [2:0] r;
  } vec_t;

  vec_t vecs[9];

  divisor_seq #(.WIDTH(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .init (init),
    .DV   (DV),
    .DR   (DR),
    .sal  (sal),
    .rem  (rem),
    .done (done),
    .dbz  (dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [2:0] dr);
`ifdef DIVISOR_ZERO_TRAP_EN
    return (dr == 3'd0) ? 1 : 3;
`else
    return 3;
`endif
  endfunction

  function automatic int exp_dbz(input logic [2:0] dr);
`ifdef DIVISOR_ZERO_TRAP_EN
    return (dr == 3'd0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // Waits for done, at most 8 edges; returns the edge count or 0 on timeout
  task automatic wait_done(output int lat);
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  // Full division: start, scramble operands after capture, check latency/result, release init
  task automatic do_div(input string nm, input logic [2:0] dv, input logic [2:0] dr,
                        input logic [2:0] q, input logic [2:0] r);
    int lat;
    DV   = dv;
    DR   = dr;
    init = 1'b1;
    @(posedge clk); #1;
    check({nm, " done_low_after_capture"}, int'(done), 0);
    DV = ~dv;
    DR = ~dr;
    lat = 1;
    if (!done) begin
      wait_done(lat);
      lat = (lat == 0) ? 0 : lat + 1;
    end
    check({nm, " latency"}, lat, exp_lat(dr) + 1);
    check({nm, " sal"}, int'(sal), int'(q));
    check({nm, " rem"}, int'(rem), int'(r));
    check({nm, " dbz"}, int'(dbz), exp_dbz(dr));
    init = 1'b0;
    @(posedge clk); #1;
    check({nm, " done_cleared"}, int'(done), 0);
    check({nm, " sal_held"}, int'(sal), int'(q));
    check({nm, " rem_held"}, int'(rem), int'(r));
    check({nm, " dbz_cleared"}, int'(dbz), 0);
  endtask

  initial begin
    int lat;

    vecs[0] = '{dv: 3'd7, dr: 3'd2, q: 3'd3, r: 3'd1};
    vecs[1] = '{dv: 3'd6, dr: 3'd3, q: 3'd2, r: 3'd0};
    vecs[2] = '{dv: 3'd0, dr: 3'd5, q: 3'd0, r: 3'd0};
    vecs[3] = '{dv: 3'd7, dr: 3'd7, q: 3'd1, r: 3'd0};
    vecs[4] = '{dv: 3'd5, dr: 3'd0, q: 3'd7, r: 3'd5};
    vecs[5] = '{dv: 3'd1, dr: 3'd3, q: 3'd0, r: 3'd1};
    vecs[6] = '{dv: 3'd3, dr: 3'd1, q: 3'd3, r: 3'd0};
    vecs[7] = '{dv: 3'd4, dr: 3'd6, q: 3'd0, r: 3'd4};
    vecs[8] = '{dv: 3'd6, dr: 3'd4, q: 3'd1, r: 3'd2};

    rst  = 1'b1;
    init = 1'b0;
    DV   = 3'd0;
    DR   = 3'd0;
    #12;
    check("reset sal", int'(sal), 0);
    check("reset rem", int'(rem), 0);
    check("reset done", int'(done), 0);
    check("reset dbz", int'(dbz), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // table-driven divisions
    for (int i = 0; i < 9; i++) begin
      do_div($sformatf("vec%0d", i), vecs[i].dv, vecs[i].dr, vecs[i].q, vecs[i].r);
    end

    // abort during CALC: prior result 6/3 must survive, done never rises
    do_div("pre_abort", 3'd6, 3'd3, 3'd2, 3'd0);
    DV = 3'd7; DR = 3'd2; init = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    init = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      check("abort done_low", int'(done), 0);
    end
    check("abort sal_kept", int'(sal), 2);
    check("abort rem_kept", int'(rem), 0);
    do_div("post_abort", 3'd7, 3'd2, 3'd3, 3'd1);

    // asynchronous reset mid-CALC
    DV = 3'd5; DR = 3'd2; init = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check("rst_calc sal", int'(sal), 0);
    check("rst_calc rem", int'(rem), 0);
    check("rst_calc done", int'(done), 0);
    init = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    do_div("after_rst_calc", 3'd6, 3'd4, 3'd1, 3'd2);

    // asynchronous reset mid-DONE
    DV = 3'd7; DR = 3'd2; init = 1'b1;
    wait_done(lat);
    check("rst_done reached", int'(lat != 0), 1);
    check("rst_done pre sal", int'(sal), 3);
    #2 rst = 1'b1;
    #1;
    check("rst_done sal", int'(sal), 0);
    check("rst_done rem", int'(rem), 0);
    check("rst_done done", int'(done), 0);
    check("rst_done dbz", int'(dbz), 0);
    init = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    do_div("after_rst_done", 3'd7, 3'd3, 3'd2, 3'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/divisor_seq.md
Name: divisor_seq

Overview:
- Sequential restoring divider: the responder side of the ALU's per-operation init handshake, filling the division slot of the ALU result multiplexer.
- Responds to a rising edge on init.
- Divides unsigned operand DV by DR one quotient bit per clock.
- Presents quotient/remainder with a done flag, holding them until the next division starts.

Parameters:
- WIDTH, 3, operand, quotient and remainder width in bits.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- init  input  1  level from the ALU opcode decoder; rising edge starts a division, must stay high to keep the result valid
- DV  input  WIDTH  dividend, unsigned
- DR  input  WIDTH  divisor, unsigned
- sal  output  WIDTH  quotient
- rem  output  WIDTH  remainder
- done  output  1  high while the result of the current init period is valid
- dbz  output  1  divide-by-zero flag (see Optional Feature)

Behaviour:
- Reset (async, rst=1): state IDLE, sal=0, rem=0, done=0, dbz=0, init_q=0, iteration count=0.
- init_q: register of init, used for edge detection; start condition is init=1 and init_q=0, sampled in IDLE only.
- States:
  - IDLE: wait for start. On start: capture DV, DR into internal registers, clear partial remainder, count=0, go to CALC.
  - CALC: one restoring step per cycle:
    - shift {partial_rem, dividend} left by 1
    - trial = partial_rem − divisor, computed WIDTH+1 bits wide
    - if trial non-negative: partial_rem=trial and quotient LSB=1; else quotient LSB=0
    - count increments; after WIDTH steps go to DONE, loading sal and rem and setting done=1 on that same edge
  - DONE: done=1. When init=0, go to IDLE and clear done on that edge; sal/rem keep their values.
- Latency: done rises exactly WIDTH clock edges after the capture edge (3 for default).
- Operands are sampled only at the capture edge; DV/DR changes afterwards are ignored.
- init falls during CALC: abort to IDLE next edge; done stays 0; sal/rem keep the previous result.
- init rises again while in DONE: impossible without a fall; a fall then rise within one cycle is handled as fall → IDLE, then the next rising edge starts a new division.
- rst during CALC/DONE: immediate return to reset values.
- DR=0 without trap: the algorithm naturally yields sal=all ones and rem=DV.
- DV=0: sal=0, rem=0.

Optional Feature:
- Macro: DIVISOR_ZERO_TRAP_EN.
- Defined: DR=0 at capture skips CALC and goes straight to DONE on the next edge (latency 1) with sal=all ones, rem=DV, dbz=1. dbz clears when leaving DONE or on reset.
- Not defined: dbz is tied to constant 0; DR=0 runs the full WIDTH-cycle algorithm with the same numeric result.

Decomposition:
- Shared package: state encodings IDLE/CALC/DONE (2-bit) and the default WIDTH constant, reused by future sequential ALU blocks.
- One natural sub-module: div_step, a combinational single restoring iteration. Inputs: partial remainder, next dividend bit, divisor. Outputs: new remainder and quotient bit.
- The FSM and registers stay in divisor_seq.

Test Plan:
- WIDTH=3, DV=7, DR=2, raise init and hold → done=1 exactly 3 edges after capture, sal=3, rem=1; drop init → done=0 next edge, sal/rem still 3/1.
- DV=6, DR=3 → sal=2, rem=0; then DV=0, DR=5 after an init low/high cycle → sal=0, rem=0; DV=7, DR=7 → sal=1, rem=0.
- DV=5, DR=0:
  - with DIVISOR_ZERO_TRAP_EN → done after 1 edge, sal=7, rem=5, dbz=1
  - without → done after 3 edges, sal=7, rem=5, dbz=0
- Start 7/2, drop init after 1 CALC cycle → IDLE, done never asserts, sal/rem unchanged from the prior result.
- Assert rst mid-CALC and mid-DONE → all outputs 0 immediately (asynchronous); next init rising edge divides normally.
- Change DV/DR during CALC → result matches operands captured at the start edge.
